// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD SPI transmitter slice.
// LCD_SPI_TX_BURST_EN (optional) keeps CS low across back-to-back FIFO words.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_GAP
  } lcd_state_e;

  localparam int unsigned LCD_DC_BIT  = 8;
  localparam int unsigned LCD_WORD_W  = 9;
  localparam int unsigned CLK_DIV_MIN = 1;

  // Counter width for 0..clk_div-1; never zero so CLK_DIV=1 still builds.
  function automatic int unsigned phase_cnt_w(input int unsigned clk_div);
    return (clk_div <= 2) ? 1 : $clog2(clk_div);
  endfunction

endpackage

// File: rtl/lcd_sck_phase.sv
// SCK half-period timer: counts 0..CLK_DIV-1 and flags the last cycle of a phase.
// Used by lcd_spi_tx; unaffected by LCD_SPI_TX_BURST_EN.
module lcd_sck_phase
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tc
);

  localparam int unsigned CW = phase_cnt_w(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tc) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lcd_spi_tx.sv
// FIFO-fed SPI mode-0 byte serialiser for an LCD with a separate D/C line.
// Define LCD_SPI_TX_BURST_EN to chain queued words without releasing CS.
module lcd_spi_tx
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [LCD_WORD_W-1:0] fifo_dout,
  output logic                  fifo_rd,
  output logic                  lcd_sck,
  output logic                  lcd_mosi,
  output logic                  lcd_dc,
  output logic                  lcd_cs_n,
  output logic                  busy
);

  lcd_state_e            state_q, state_d;
  logic [LCD_WORD_W-1:0] shreg_q, shreg_d;
  logic [2:0]            bit_q, bit_d;
  logic                  last_q, last_d;
  logic                  sck_q, sck_d;
  logic                  mosi_q, mosi_d;
  logic                  dc_q, dc_d;
  logic                  cs_n_q, cs_n_d;
  logic                  busy_q, busy_d;
  logic                  pop;
  logic                  tc;
  logic [7:0]            byte_d;

  lcd_sck_phase #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk (clk),
    .rst (rst),
    .clr (state_q == ST_IDLE),
    .tc  (tc)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    last_d  = last_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE:  pop = !fifo_empty;
      ST_SETUP: if (tc) state_d = ST_HIGH;
      ST_HIGH: begin
        if (tc) begin
          state_d = ST_LOW;
          bit_d   = bit_q - 3'd1;
          last_d  = (bit_q == 3'd0);
        end
      end
      ST_LOW: begin
        if (tc) begin
          if (!last_q) begin
            state_d = ST_HIGH;
          end else begin
`ifdef LCD_SPI_TX_BURST_EN
            if (!fifo_empty) pop = 1'b1;
            else             state_d = ST_GAP;
`else
            state_d = ST_GAP;
`endif
          end
        end
      end
      // A word already waiting at the end of the gap is taken here so CS
      // is high for exactly CLK_DIV cycles between queued frames.
      ST_GAP: begin
        if (tc) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      shreg_d = fifo_dout;
      state_d = ST_SETUP;
      bit_d   = 3'd7;
      last_d  = 1'b0;
    end
    fifo_rd = pop && !rst;
  end

  // Pin values are decoded from the next state so they line up with state_q.
  always_comb begin
    byte_d = shreg_d[7:0];
    cs_n_d = 1'b1;
    sck_d  = 1'b0;
    mosi_d = 1'b0;
    dc_d   = dc_q;
    busy_d = (state_d != ST_IDLE);
    unique case (state_d)
      ST_SETUP: begin
        cs_n_d = 1'b0;
        dc_d   = shreg_d[LCD_DC_BIT];
        mosi_d = byte_d[7];
      end
      ST_HIGH: begin
        cs_n_d = 1'b0;
        sck_d  = 1'b1;
        mosi_d = mosi_q;
      end
      ST_LOW: begin
        cs_n_d = 1'b0;
        mosi_d = last_d ? mosi_q : byte_d[bit_d];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bit_q   <= 3'd7;
      last_q  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      dc_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      dc_q    <= dc_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
    end
  end

  assign lcd_sck  = sck_q;
  assign lcd_mosi = mosi_q;
  assign lcd_dc   = dc_q;
  assign lcd_cs_n = cs_n_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_lcd_spi_tx.sv
// Directed bench for lcd_spi_tx at CLK_DIV=2 with a 16-deep 9-bit SRL FIFO model.
// Expectations follow LCD_SPI_TX_BURST_EN when it is defined.
module tb_lcd_spi_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty;
  logic [8:0] fifo_dout;
  logic       fifo_rd;
  logic       lcd_sck, lcd_mosi, lcd_dc, lcd_cs_n, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcd_spi_tx #(.CLK_DIV(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd    (fifo_rd),
    .lcd_sck    (lcd_sck),
    .lcd_mosi   (lcd_mosi),
    .lcd_dc     (lcd_dc),
    .lcd_cs_n   (lcd_cs_n),
    .busy       (busy)
  );

  // FIFO model: head at mem[0], asynchronous read.
  logic [8:0]  mem [16];
  logic [8:0]  mem_nx [16];
  int unsigned cnt = 0;
  int unsigned cnt_nx;
  logic        wr_en = 1'b0;
  logic [8:0]  wr_data = '0;

  assign fifo_empty = (cnt == 0);
  assign fifo_dout  = mem[0];

  initial for (int i = 0; i < 16; i++) mem[i] = '0;

  always @(posedge clk) begin
    mem_nx = mem;
    cnt_nx = cnt;
    if (fifo_rd && cnt_nx != 0) begin
      for (int i = 0; i < 15; i++) mem_nx[i] = mem_nx[i+1];
      cnt_nx = cnt_nx - 1;
    end
    if (wr_en && cnt_nx < 16) begin
      mem_nx[cnt_nx] = wr_data;
      cnt_nx = cnt_nx + 1;
    end
    mem <= mem_nx;
    cnt <= cnt_nx;
  end

  // Line monitor, sampled on the falling clock edge.
  logic [8:0] rx_q [$];
  logic [7:0] sh = '0;
  logic       fdc = 1'b0;
  logic       sck_prev = 1'b0;
  logic       cs_prev = 1'b1;
  int         bit_n = 0;
  int         rd_cnt = 0;
  int         dc_glitch = 0;
  int         dc_hi_low = 0;
  int         low_run = 0, high_run = 0;
  int         last_low = 0, last_high = 0;

  always @(negedge clk) begin
    if (fifo_rd) rd_cnt++;
    if (lcd_cs_n) begin
      bit_n = 0;
    end else if (lcd_sck && !sck_prev) begin
      sh = {sh[6:0], lcd_mosi};
      if (bit_n == 0) fdc = lcd_dc;
      else if (lcd_dc != fdc) dc_glitch++;
      bit_n++;
      if (bit_n == 8) begin
        rx_q.push_back({fdc, sh});
        bit_n = 0;
      end
    end
    if (!lcd_cs_n && lcd_dc) dc_hi_low++;
    if (!lcd_cs_n) begin
      if (cs_prev) begin last_high = high_run; high_run = 0; end
      low_run++;
    end else begin
      if (!cs_prev) begin last_low = low_run; low_run = 0; end
      high_run++;
    end
    sck_prev = lcd_sck;
    cs_prev  = lcd_cs_n;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [8:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while ((busy || !fifo_empty) && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, busy || !fifo_empty}, 32'd0);
  endtask

  task automatic expect_frame(input string tag, input logic [8:0] w);
    logic [8:0] got;
    if (rx_q.size() == 0) begin
      check({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      got = rx_q.pop_front();
      check(tag, {23'd0, got}, {23'd0, w});
    end
  endtask

  logic [8:0]  words [16];
  int          n, rd0, dch0, viol;
  int unsigned cnt0;

  initial begin
    // 1: reset, then idle with an empty FIFO
    repeat (3) @(negedge clk);
    check("rst_cs_n", {31'd0, lcd_cs_n}, 32'd1);
    check("rst_sck",  {31'd0, lcd_sck},  32'd0);
    check("rst_mosi", {31'd0, lcd_mosi}, 32'd0);
    check("rst_dc",   {31'd0, lcd_dc},   32'd0);
    check("rst_busy", {31'd0, busy},     32'd0);
    check("rst_rd",   {31'd0, fifo_rd},  32'd0);
    rst = 1'b0;
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (lcd_cs_n !== 1'b1 || lcd_sck !== 1'b0 || fifo_rd !== 1'b0 || busy !== 1'b0) viol++;
    end
    check("idle_viol", viol, 0);
    rx_q.delete();

    // 2: 0x1A5, latency and CS window
    rd0 = rd_cnt;
    push(9'h1A5);
    n = 0;
    while (!fifo_rd && n < 10) begin @(negedge clk); n++; end
    check("t2_pop_seen", {31'd0, fifo_rd}, 32'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 100);
    check("t2_byte_time", n, 37);
    check("t2_cs_low", last_low, 34);
    check("t2_pops", rd_cnt - rd0, 1);
    check("t2_dc_glitch", dc_glitch, 0);
    expect_frame("t2_frame", 9'h1A5);

    // 3: command byte 0x03C, dc low throughout
    rd0  = rd_cnt;
    dch0 = dc_hi_low;
    push(9'h03C);
    wait_idle("t3_idle", 200);
    check("t3_dc_low", dc_hi_low - dch0, 0);
    check("t3_pops", rd_cnt - rd0, 1);
    expect_frame("t3_frame", 9'h03C);

    // 4: back-to-back 0x1FF, 0x000
    rd0 = rd_cnt;
    push(9'h1FF);
    push(9'h000);
    wait_idle("t4_idle", 300);
    check("t4_pops", rd_cnt - rd0, 2);
`ifdef LCD_SPI_TX_BURST_EN
    check("t4_cs_low_burst", last_low, 68);
`else
    check("t4_cs_gap", last_high, 2);
    check("t4_cs_low", last_low, 34);
`endif
    expect_frame("t4_frame0", 9'h1FF);
    expect_frame("t4_frame1", 9'h000);
    check("t4_dc_glitch", dc_glitch, 0);

    // 5: reset during bit 4 of 0x155, 0x0C3 queued behind it
    rx_q.delete();
    rd0 = rd_cnt;
    push(9'h155);
    push(9'h0C3);
    n = 0;
    while (bit_n != 4 && n < 200) begin @(negedge clk); n++; end
    check("t5_reach_bit4", bit_n, 4);
    cnt0 = cnt;
    rst = 1'b1;
    @(negedge clk);
    check("t5_abort_cs_n", {31'd0, lcd_cs_n}, 32'd1);
    check("t5_abort_sck",  {31'd0, lcd_sck},  32'd0);
    check("t5_abort_busy", {31'd0, busy},     32'd0);
    check("t5_abort_rd",   {31'd0, fifo_rd},  32'd0);
    check("t5_fifo_cnt", cnt, cnt0);
    rst = 1'b0;
    wait_idle("t5_idle", 200);
    check("t5_pops", rd_cnt - rd0, 2);
    check("t5_frames", rx_q.size(), 1);
    expect_frame("t5_frame", 9'h0C3);

    // 6: sixteen words queued in a row
    rx_q.delete();
    rd0 = rd_cnt;
    for (int i = 0; i < 16; i++) begin
      words[i] = {i[0], 8'(i * 29 + 7)};
      push(words[i]);
    end
    wait_idle("t6_idle", 1000);
    check("t6_pops", rd_cnt - rd0, 16);
    check("t6_frames", rx_q.size(), 16);
    for (int i = 0; i < 16; i++) expect_frame($sformatf("t6_frame%0d", i), words[i]);
    check("t6_empty", {31'd0, fifo_empty}, 32'd1);
    check("t6_dc_glitch", dc_glitch, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
